// File: rtl/hint_mem_sequencer.sv
// hint_mem_sequencer: issues the (up to) two memory hints of one trace step
// in order over a single shared request/response port, checks read data
// against the claimed value and reports one verdict per step.
module hint_mem_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_valid,
    output logic        step_ready,
    input  logic [1:0]  hint1_mask,
    input  logic        hint1_rw,
    input  logic [31:0] hint1_address,
    input  logic [31:0] hint1_data,
    input  logic [1:0]  hint2_mask,
    input  logic        hint2_rw,
    input  logic [31:0] hint2_address,
    input  logic [31:0] hint2_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_be,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [1:0]  done_fault,
    output logic        done_fault_hint
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE1, ST_WAIT1, ST_ISSUE2, ST_WAIT2, ST_DONE
    } state_t;

    localparam logic [1:0] FAULT_OK       = 2'd0;
    localparam logic [1:0] FAULT_MISMATCH = 2'd1;
    localparam logic [1:0] FAULT_ALIGN    = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    state_t                 state_reg;
    logic [TIMEOUT_W-1:0]   cnt_reg;
    logic [1:0]             h1_mask_reg, h2_mask_reg;
    logic                   h1_rw_reg, h2_rw_reg;
    logic [31:0]            h1_addr_reg, h2_addr_reg;
    logic [31:0]            h1_data_reg, h2_data_reg;

    // Access size in bytes for a used mask (1, 2 or 4).
    function automatic logic [2:0] size_bytes(input logic [1:0] mask);
        case (mask)
            2'd1:    return 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // An access that would cross the dword boundary cannot be issued.
    function automatic logic is_misaligned(input logic [1:0] mask, input logic [31:0] addr);
        return ({1'b0, addr[1:0]} + size_bytes(mask)) > 3'd4;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] mask, input logic [31:0] addr);
        logic [3:0] base;
        case (mask)
            2'd1:    base = 4'b0001;
            2'd2:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << addr[1:0];
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] mask);
        case (mask)
            2'd1:    return 32'h0000_00FF;
            2'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Candidate hint for the next request: straight from the inputs when a
    // step is being accepted (1-cycle accept-to-request), else the latched
    // second hint.
    logic [1:0]  iss_mask;
    logic        iss_rw;
    logic [31:0] iss_addr, iss_data;
    always_comb begin
        iss_mask = h2_mask_reg;
        iss_rw   = h2_rw_reg;
        iss_addr = h2_addr_reg;
        iss_data = h2_data_reg;
        if (state_reg == ST_IDLE) begin
            if (hint1_mask != 2'd0) begin
                iss_mask = hint1_mask;
                iss_rw   = hint1_rw;
                iss_addr = hint1_address;
                iss_data = hint1_data;
            end else begin
                iss_mask = hint2_mask;
                iss_rw   = hint2_rw;
                iss_addr = hint2_address;
                iss_data = hint2_data;
            end
        end
    end

    // Hint currently awaiting its response and the read-data comparison.
    logic        cur_is_h2;
    logic [1:0]  cur_mask;
    logic        cur_rw;
    logic [31:0] cur_addr, cur_data;
    logic        rd_match;
    always_comb begin
        cur_is_h2 = (state_reg == ST_WAIT2);
        cur_mask  = cur_is_h2 ? h2_mask_reg : h1_mask_reg;
        cur_rw    = cur_is_h2 ? h2_rw_reg   : h1_rw_reg;
        cur_addr  = cur_is_h2 ? h2_addr_reg : h1_addr_reg;
        cur_data  = cur_is_h2 ? h2_data_reg : h1_data_reg;
        rd_match  = ((mem_rsp_rdata >> {cur_addr[1:0], 3'b000}) & size_mask(cur_mask))
                    == (cur_data & size_mask(cur_mask));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            step_ready      <= 1'b1;
            mem_req_valid   <= 1'b0;
            mem_req_we      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_be      <= '0;
            mem_req_wdata   <= '0;
            done_valid      <= 1'b0;
            done_fault      <= FAULT_OK;
            done_fault_hint <= 1'b0;
            h1_mask_reg     <= '0;
            h1_rw_reg       <= 1'b0;
            h1_addr_reg     <= '0;
            h1_data_reg     <= '0;
            h2_mask_reg     <= '0;
            h2_rw_reg       <= 1'b0;
            h2_addr_reg     <= '0;
            h2_data_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (step_valid && step_ready) begin
                        h1_mask_reg <= hint1_mask;
                        h1_rw_reg   <= hint1_rw;
                        h1_addr_reg <= hint1_address;
                        h1_data_reg <= hint1_data;
                        h2_mask_reg <= hint2_mask;
                        h2_rw_reg   <= hint2_rw;
                        h2_addr_reg <= hint2_address;
                        h2_data_reg <= hint2_data;
                        step_ready  <= 1'b0;
                        if (hint1_mask == 2'd0 && hint2_mask == 2'd0) begin
                            state_reg       <= ST_DONE;
                            done_valid      <= 1'b1;
                            done_fault      <= FAULT_OK;
                            done_fault_hint <= 1'b0;
                        end else if (is_misaligned(iss_mask, iss_addr)) begin
                            state_reg       <= ST_DONE;
                            done_valid      <= 1'b1;
                            done_fault      <= FAULT_ALIGN;
                            done_fault_hint <= (hint1_mask == 2'd0);
                        end else begin
                            state_reg     <= (hint1_mask != 2'd0) ? ST_ISSUE1 : ST_ISSUE2;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= iss_rw;
                            mem_req_addr  <= {iss_addr[31:2], 2'b00};
                            mem_req_be    <= byte_en(iss_mask, iss_addr);
                            mem_req_wdata <= iss_data << {iss_addr[1:0], 3'b000};
                        end
                    end
                end
                ST_ISSUE1, ST_ISSUE2: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= (state_reg == ST_ISSUE1) ? ST_WAIT1 : ST_WAIT2;
                    end
                end
                ST_WAIT1, ST_WAIT2: begin
                    if (mem_rsp_valid) begin
                        if (!cur_rw && !rd_match) begin
                            state_reg       <= ST_DONE;
                            done_valid      <= 1'b1;
                            done_fault      <= FAULT_MISMATCH;
                            done_fault_hint <= cur_is_h2;
                        end else if (!cur_is_h2 && h2_mask_reg != 2'd0) begin
                            if (is_misaligned(iss_mask, iss_addr)) begin
                                state_reg       <= ST_DONE;
                                done_valid      <= 1'b1;
                                done_fault      <= FAULT_ALIGN;
                                done_fault_hint <= 1'b1;
                            end else begin
                                state_reg     <= ST_ISSUE2;
                                mem_req_valid <= 1'b1;
                                mem_req_we    <= iss_rw;
                                mem_req_addr  <= {iss_addr[31:2], 2'b00};
                                mem_req_be    <= byte_en(iss_mask, iss_addr);
                                mem_req_wdata <= iss_data << {iss_addr[1:0], 3'b000};
                            end
                        end else begin
                            state_reg       <= ST_DONE;
                            done_valid      <= 1'b1;
                            done_fault      <= FAULT_OK;
                            done_fault_hint <= 1'b0;
                        end
                    end else if (cnt_reg == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This cycle brings the wait count to TIMEOUT_CYCLES.
                        cnt_reg         <= cnt_reg + TIMEOUT_W'(1);
                        state_reg       <= ST_DONE;
                        done_valid      <= 1'b1;
                        done_fault      <= FAULT_TIMEOUT;
                        done_fault_hint <= cur_is_h2;
                    end else begin
                        cnt_reg <= cnt_reg + TIMEOUT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        state_reg       <= ST_IDLE;
                        done_valid      <= 1'b0;
                        done_fault      <= FAULT_OK;
                        done_fault_hint <= 1'b0;
                        step_ready      <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hint_mem_sequencer.sv
// Directed testbench for hint_mem_sequencer with hand-computed expectations.
module tb_hint_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_valid = 1'b0;
    logic        step_ready;
    logic [1:0]  hint1_mask = '0, hint2_mask = '0;
    logic        hint1_rw = 1'b0, hint2_rw = 1'b0;
    logic [31:0] hint1_address = '0, hint2_address = '0;
    logic [31:0] hint1_data = '0, hint2_data = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [1:0]  done_fault;
    logic        done_fault_hint;

    int checks = 0;
    int failures = 0;
    int req_count = 0;

    hint_mem_sequencer #(.TIMEOUT_CYCLES(255), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .step_valid(step_valid), .step_ready(step_ready),
        .hint1_mask(hint1_mask), .hint1_rw(hint1_rw),
        .hint1_address(hint1_address), .hint1_data(hint1_data),
        .hint2_mask(hint2_mask), .hint2_rw(hint2_rw),
        .hint2_address(hint2_address), .hint2_data(hint2_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_fault(done_fault), .done_fault_hint(done_fault_hint)
    );

    always #5 clk = ~clk;

    // Count request handshakes seen on the memory port.
    always @(posedge clk) begin
        if (rst_n && mem_req_valid && mem_req_ready) req_count <= req_count + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hints(input logic [1:0] m1, input logic rw1, input logic [31:0] a1,
                             input logic [31:0] d1, input logic [1:0] m2, input logic rw2,
                             input logic [31:0] a2, input logic [31:0] d2);
        hint1_mask = m1; hint1_rw = rw1; hint1_address = a1; hint1_data = d1;
        hint2_mask = m2; hint2_rw = rw2; hint2_address = a2; hint2_data = d2;
    endtask

    task automatic start_step();
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
    endtask

    // Wait for a request, check its fields, accept it, optionally respond.
    task automatic serve_req(input string tag, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic do_rsp, input logic [31:0] rdata);
        int n = 0;
        while (!mem_req_valid && n < 20) begin tick(); n++; end
        check_value({tag, "_req_valid"}, mem_req_valid, 1);
        check_value({tag, "_req_we"}, mem_req_we, we);
        check_value({tag, "_req_addr"}, mem_req_addr, addr);
        check_value({tag, "_req_be"}, mem_req_be, be);
        check_value({tag, "_req_wdata"}, mem_req_wdata, wdata);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_value({tag, "_req_drop"}, mem_req_valid, 0);
        $display("req %s: we=%0d addr=0x%08h be=0x%h wdata=0x%08h", tag, mem_req_we,
                 mem_req_addr, mem_req_be, mem_req_wdata);
        if (do_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            tick();
            mem_rsp_valid = 1'b0;
        end
    endtask

    // Wait for the verdict, check it is held, then consume it.
    task automatic wait_done(input string tag, input logic [1:0] ef, input logic eh);
        int n = 0;
        while (!done_valid && n < 300) begin tick(); n++; end
        check_value({tag, "_done_valid"}, done_valid, 1);
        check_value({tag, "_fault"}, done_fault, ef);
        check_value({tag, "_fault_hint"}, done_fault_hint, eh);
        check_value({tag, "_step_ready_busy"}, step_ready, 0);
        tick();
        check_value({tag, "_done_hold"}, done_valid, 1);
        check_value({tag, "_fault_hold"}, done_fault, ef);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check_value({tag, "_done_clear"}, done_valid, 0);
        check_value({tag, "_step_ready_back"}, step_ready, 1);
        $display("step %s: fault=%0d fault_hint=%0d", tag, done_fault, done_fault_hint);
    endtask

    initial begin
        int base;
        int n;

        // Reset values
        tick(); tick();
        check_value("rst_step_ready", step_ready, 1);
        check_value("rst_req_valid", mem_req_valid, 0);
        check_value("rst_req_we", mem_req_we, 0);
        check_value("rst_req_addr", mem_req_addr, 0);
        check_value("rst_req_be", mem_req_be, 0);
        check_value("rst_req_wdata", mem_req_wdata, 0);
        check_value("rst_done_valid", done_valid, 0);
        check_value("rst_done_fault", done_fault, 0);
        check_value("rst_fault_hint", done_fault_hint, 0);
        rst_n = 1'b1;
        tick();

        // Both hints unused: verdict the cycle after accept, no request
        base = req_count;
        set_hints(2'd0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0);
        start_step();
        check_value("empty_done_next", done_valid, 1);
        check_value("empty_no_req", mem_req_valid, 0);
        wait_done("empty", 2'd0, 1'b0);
        check_value("empty_req_count", req_count - base, 0);

        // Dword read match
        base = req_count;
        set_hints(2'd3, 1'b0, 32'h1000, 32'hDEADBEEF, 2'd0, 1'b0, 32'h0, 32'h0);
        start_step();
        check_value("rd32_latency", mem_req_valid, 1);
        serve_req("rd32", 1'b0, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        wait_done("rd32", 2'd0, 1'b0);
        check_value("rd32_req_count", req_count - base, 1);

        // Byte write then word read with mismatching data
        base = req_count;
        set_hints(2'd1, 1'b1, 32'h2003, 32'hAB, 2'd2, 1'b0, 32'h10, 32'h1234);
        start_step();
        serve_req("wr8", 1'b1, 32'h2000, 4'h8, 32'hAB000000, 1'b1, 32'h0);
        serve_req("rd16", 1'b0, 32'h10, 4'h3, 32'h1234, 1'b1, 32'h00001235);
        wait_done("wr8_rd16", 2'd1, 1'b1);
        check_value("wr8_rd16_req_count", req_count - base, 2);

        // Upper-half word read and offset byte read, both matching
        set_hints(2'd2, 1'b0, 32'h0402, 32'hBEEF, 2'd1, 1'b0, 32'h0501, 32'h5A);
        start_step();
        serve_req("rd16_hi", 1'b0, 32'h0400, 4'hC, 32'hBEEF0000, 1'b1, 32'hBEEF1111);
        serve_req("rd8_b1", 1'b0, 32'h0500, 4'h2, 32'h00005A00, 1'b1, 32'h77665A44);
        wait_done("rd_offsets", 2'd0, 1'b0);

        // Misaligned first hint: no request at all
        base = req_count;
        set_hints(2'd2, 1'b0, 32'h3003, 32'h0, 2'd3, 1'b0, 32'h0, 32'h0);
        start_step();
        check_value("mis1_no_req", mem_req_valid, 0);
        wait_done("mis1", 2'd2, 1'b0);
        check_value("mis1_req_count", req_count - base, 0);

        // Misaligned second hint only
        set_hints(2'd0, 1'b0, 32'h0, 32'h0, 2'd3, 1'b1, 32'h0005, 32'h0);
        start_step();
        check_value("mis2_no_req", mem_req_valid, 0);
        wait_done("mis2", 2'd2, 1'b1);

        // Timeout on the first hint; the second must never be issued
        base = req_count;
        set_hints(2'd3, 1'b0, 32'h40, 32'h1, 2'd3, 1'b0, 32'h44, 32'h2);
        start_step();
        serve_req("to", 1'b0, 32'h40, 4'hF, 32'h1, 1'b0, 32'h0);
        n = 0;
        while (!done_valid && n < 400) begin tick(); n++; end
        check_value("to_cycles", n, 255);
        wait_done("to", 2'd3, 1'b0);
        check_value("to_req_count", req_count - base, 1);

        // Response arriving on the final timeout cycle wins
        set_hints(2'd3, 1'b0, 32'h48, 32'hCAFEF00D, 2'd0, 1'b0, 32'h0, 32'h0);
        start_step();
        serve_req("race", 1'b0, 32'h48, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        for (int i = 0; i < 254; i++) tick();
        check_value("race_not_done", done_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFEF00D;
        tick();
        mem_rsp_valid = 1'b0;
        wait_done("race", 2'd0, 1'b0);

        // Back-pressure: request fields held while mem_req_ready is low
        set_hints(2'd3, 1'b1, 32'h80, 32'h11223344, 2'd0, 1'b0, 32'h0, 32'h0);
        start_step();
        for (int i = 0; i < 5; i++) begin
            check_value("stall_valid", mem_req_valid, 1);
            check_value("stall_addr", mem_req_addr, 32'h80);
            check_value("stall_wdata", mem_req_wdata, 32'h11223344);
            check_value("stall_be", mem_req_be, 4'hF);
            tick();
        end
        serve_req("stall", 1'b1, 32'h80, 4'hF, 32'h11223344, 1'b1, 32'h0);
        wait_done("stall", 2'd0, 1'b0);

        // Stray response in IDLE is ignored
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        check_value("stray_no_done", done_valid, 0);
        check_value("stray_ready", step_ready, 1);

        // Reset in WAIT1 returns outputs asynchronously; late response ignored
        set_hints(2'd3, 1'b0, 32'hC0, 32'h5, 2'd0, 1'b0, 32'h0, 32'h0);
        start_step();
        serve_req("rstmid", 1'b0, 32'hC0, 4'hF, 32'h5, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_value("rstmid_step_ready", step_ready, 1);
        check_value("rstmid_req_valid", mem_req_valid, 0);
        check_value("rstmid_req_addr", mem_req_addr, 0);
        check_value("rstmid_req_be", mem_req_be, 0);
        check_value("rstmid_done_valid", done_valid, 0);
        tick();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        check_value("rstmid_after_done", done_valid, 0);
        check_value("rstmid_after_ready", step_ready, 1);
        check_value("rstmid_after_req", mem_req_valid, 0);
        $display("step rstmid: reset during wait, idle afterwards");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
